// File: rtl/transport_link_if.sv
// Session/link-facing bundle of the transport layer: command framing in, byte link out/in, delivery strobes out.
// master is the transport_link side; slave is the session/link environment driving it.
interface transport_link_if;
    logic [1:0]  cmd;
    logic [15:0] dataIn;
    logic        transportBusy;
    logic [1:0]  cmdOut;
    logic [15:0] packetOut;
    logic        sessionBusy;
    logic [7:0]  txByte;
    logic        txValid;
    logic        txReady;
    logic [7:0]  rxByte;
    logic        rxValid;
    logic        rxError;
    logic        rxOverflow;

    modport master (
        input  cmd, dataIn, sessionBusy, txReady, rxByte, rxValid,
        output transportBusy, cmdOut, packetOut, txByte, txValid, rxError, rxOverflow
    );

    modport slave (
        output cmd, dataIn, sessionBusy, txReady, rxByte, rxValid,
        input  transportBusy, cmdOut, packetOut, txByte, txValid, rxError, rxOverflow
    );
endinterface

// File: rtl/transport_link.sv
// Frames session commands into 3-byte link frames and parses 3-byte frames back; TX busy/valid 1 cycle after request, RX delivery 2 cycles after last byte.
// TX bytes hold until txReady; RX delivery waits on sessionBusy with one pending slot, later frames dropped with rxOverflow.
module transport_link #(
    parameter logic [3:0] SYNC       = 4'hA,
    parameter int         RX_TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    transport_link_if.master  link
);

    localparam int CW = ($clog2(RX_TIMEOUT + 1) > 8) ? $clog2(RX_TIMEOUT + 1) : 8;
    localparam logic [CW-1:0] IDLE_LAST = CW'(RX_TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_ONE   = {{(CW-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {T_IDLE, T_HDR, T_HI, T_LO} tx_state_t;
    typedef enum logic [1:0] {R_HDR, R_HI, R_LO} rx_state_t;

    tx_state_t   tx_state;
    logic [15:0] tx_data;

    rx_state_t   rx_state;
    logic [1:0]  rx_cmd;
    logic [7:0]  rx_hi;
    logic [CW-1:0] idle_cnt;
    logic        pending;
    logic [1:0]  pend_cmd;
    logic [15:0] pend_data;

    logic hdr_ok;
    logic frame_done;
    logic deliver;

    assign hdr_ok     = (link.rxByte[7:4] == SYNC) && (link.rxByte[3:2] == 2'b00)
                        && (link.rxByte[1:0] != 2'b00);
    assign frame_done = (rx_state == R_LO) && link.rxValid;
    assign deliver    = pending && !link.sessionBusy;

    // txValid is high in every non-idle state, so txReady alone is the handshake.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_state           <= T_IDLE;
            tx_data            <= '0;
            link.txByte        <= '0;
            link.txValid       <= 1'b0;
            link.transportBusy <= 1'b0;
        end else begin
            case (tx_state)
                T_IDLE: if (link.cmd != 2'b00) begin
                    tx_data            <= link.dataIn;
                    link.txByte        <= {SYNC, 2'b00, link.cmd};
                    link.txValid       <= 1'b1;
                    link.transportBusy <= 1'b1;
                    tx_state           <= T_HDR;
                end
                T_HDR: if (link.txReady) begin
                    link.txByte <= tx_data[15:8];
                    tx_state    <= T_HI;
                end
                T_HI: if (link.txReady) begin
                    link.txByte <= tx_data[7:0];
                    tx_state    <= T_LO;
                end
                T_LO: if (link.txReady) begin
                    link.txByte        <= '0;
                    link.txValid       <= 1'b0;
                    link.transportBusy <= 1'b0;
                    tx_state           <= T_IDLE;
                end
                default: tx_state <= T_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_state     <= R_HDR;
            rx_cmd       <= '0;
            rx_hi        <= '0;
            idle_cnt     <= '0;
            link.rxError <= 1'b0;
        end else begin
            link.rxError <= 1'b0;
            case (rx_state)
                R_HDR: begin
                    idle_cnt <= '0;
                    if (link.rxValid) begin
                        if (hdr_ok) begin
                            rx_cmd   <= link.rxByte[1:0];
                            rx_state <= R_HI;
                        end else begin
                            link.rxError <= 1'b1;
                        end
                    end
                end
                R_HI, R_LO: begin
                    if (link.rxValid) begin
                        idle_cnt <= '0;
                        if (rx_state == R_HI) begin
                            rx_hi    <= link.rxByte;
                            rx_state <= R_LO;
                        end else begin
                            rx_state <= R_HDR;
                        end
                    end else if (idle_cnt == IDLE_LAST) begin
                        link.rxError <= 1'b1;
                        idle_cnt     <= '0;
                        rx_state     <= R_HDR;
                    end else begin
                        idle_cnt <= idle_cnt + CNT_ONE;
                    end
                end
                default: rx_state <= R_HDR;
            endcase
        end
    end

    // A frame completing in the cycle the slot drains takes the slot instead of being dropped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending         <= 1'b0;
            pend_cmd        <= '0;
            pend_data       <= '0;
            link.cmdOut     <= '0;
            link.packetOut  <= '0;
            link.rxOverflow <= 1'b0;
        end else begin
            link.cmdOut     <= '0;
            link.rxOverflow <= 1'b0;
            if (deliver) begin
                link.cmdOut    <= pend_cmd;
                link.packetOut <= pend_data;
            end
            if (frame_done) begin
                if (pending && !deliver) begin
                    link.rxOverflow <= 1'b1;
                end else begin
                    pending   <= 1'b1;
                    pend_cmd  <= rx_cmd;
                    pend_data <= {rx_hi, link.rxByte};
                end
            end else if (deliver) begin
                pending <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_transport_link.sv
// Directed literal checks plus randomized traffic compared every cycle against a frame-level model.
module tb_transport_link;
    localparam logic [3:0] SYNC = 4'hA;
    localparam int T = 16;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    transport_link_if bus();

    transport_link #(.SYNC(SYNC), .RX_TIMEOUT(T)) dut (
        .clk   (clk),
        .reset (reset),
        .link  (bus)
    );

    int vectors = 0;
    int miscompares = 0;
    bit checking = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model state: bytes remaining in the TX frame, bytes collected of the RX frame.
    int          tx_left;
    logic [7:0]  tx_fr [3];
    int          rx_n;
    int          rx_idle;
    logic [7:0]  rx_buf [3];
    bit          pend;
    logic [1:0]  pend_cmd;
    logic [15:0] pend_dat;
    logic [1:0]  m_cmdout;
    logic [15:0] m_pkt;
    bit          m_err;
    bit          m_ovf;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_left = 0; rx_n = 0; rx_idle = 0; pend = 0;
            m_cmdout = 0; m_pkt = 0; m_err = 0; m_ovf = 0;
        end else begin
            bit done;
            done = 0;
            if (tx_left == 0) begin
                if (bus.cmd != 2'b00) begin
                    tx_fr[0] = {SYNC, 2'b00, bus.cmd};
                    tx_fr[1] = bus.dataIn[15:8];
                    tx_fr[2] = bus.dataIn[7:0];
                    tx_left = 3;
                end
            end else if (bus.txReady) begin
                tx_left = tx_left - 1;
            end

            m_err = 0; m_ovf = 0;
            if (bus.rxValid) begin
                rx_idle = 0;
                if (rx_n == 0) begin
                    if ((bus.rxByte >> 4) == 8'(SYNC) && ((bus.rxByte >> 2) & 8'd3) == 0
                        && (bus.rxByte & 8'd3) != 0) begin
                        rx_buf[0] = bus.rxByte;
                        rx_n = 1;
                    end else begin
                        m_err = 1;
                    end
                end else begin
                    rx_buf[rx_n] = bus.rxByte;
                    rx_n = rx_n + 1;
                    if (rx_n == 3) begin
                        done = 1;
                        rx_n = 0;
                    end
                end
            end else if (rx_n > 0) begin
                rx_idle = rx_idle + 1;
                if (rx_idle == T) begin
                    m_err = 1;
                    rx_n = 0;
                    rx_idle = 0;
                end
            end

            m_cmdout = 0;
            if (pend && !bus.sessionBusy) begin
                m_cmdout = pend_cmd;
                m_pkt = pend_dat;
                pend = 0;
            end
            if (done) begin
                if (pend) begin
                    m_ovf = 1;
                end else begin
                    pend = 1;
                    pend_cmd = rx_buf[0][1:0];
                    pend_dat = {rx_buf[1], rx_buf[2]};
                end
            end
        end
    end

    always @(negedge clk) begin
        if (checking) begin
            chk("transportBusy", 32'(bus.transportBusy), 32'(tx_left > 0));
            chk("txValid", 32'(bus.txValid), 32'(tx_left > 0));
            if (tx_left > 0)
                chk("txByte", 32'(bus.txByte), 32'(tx_fr[3 - tx_left]));
            chk("cmdOut", 32'(bus.cmdOut), 32'(m_cmdout));
            chk("packetOut", 32'(bus.packetOut), 32'(m_pkt));
            chk("rxError", 32'(bus.rxError), 32'(m_err));
            chk("rxOverflow", 32'(bus.rxOverflow), 32'(m_ovf));
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic rx_send(input logic [7:0] b);
        bus.rxByte = b;
        bus.rxValid = 1'b1;
        tick();
        bus.rxValid = 1'b0;
    endtask

    int rx_pos = 0;
    int gap = 0;

    initial begin
        bus.cmd = 2'b00; bus.dataIn = '0; bus.sessionBusy = 1'b0; bus.txReady = 1'b0;
        bus.rxByte = '0; bus.rxValid = 1'b0;
        reset = 1'b1;
        repeat (2) tick();
        chk("rst txByte", 32'(bus.txByte), 32'h0);
        chk("rst txValid", 32'(bus.txValid), 32'h0);
        chk("rst transportBusy", 32'(bus.transportBusy), 32'h0);
        chk("rst cmdOut", 32'(bus.cmdOut), 32'h0);
        chk("rst packetOut", 32'(bus.packetOut), 32'h0);
        chk("rst rxError", 32'(bus.rxError), 32'h0);
        chk("rst rxOverflow", 32'(bus.rxOverflow), 32'h0);
        #2 reset = 1'b0;
        checking = 1'b1;
        tick();

        // Basic TX frame with txReady held high
        bus.cmd = 2'b01; bus.dataIn = 16'h3005; bus.txReady = 1'b1;
        tick();
        chk("tx1 hdr", 32'(bus.txByte), 32'hA1);
        chk("tx1 busy", 32'(bus.transportBusy), 32'h1);
        bus.cmd = 2'b00;
        tick(); chk("tx1 hi", 32'(bus.txByte), 32'h30);
        tick(); chk("tx1 lo", 32'(bus.txByte), 32'h05);
        chk("tx1 busy3", 32'(bus.transportBusy), 32'h1);
        tick(); chk("tx1 done", 32'(bus.transportBusy), 32'h0);

        // Backpressure in the high-byte state, dataIn churn ignored
        bus.cmd = 2'b11; bus.dataIn = 16'hBEEF;
        tick(); chk("tx2 hdr", 32'(bus.txByte), 32'hA3);
        bus.cmd = 2'b00; bus.dataIn = 16'h1111;
        tick(); chk("tx2 hi", 32'(bus.txByte), 32'hBE);
        bus.txReady = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus.dataIn = 16'($urandom);
            tick();
            chk("tx2 hold byte", 32'(bus.txByte), 32'hBE);
            chk("tx2 hold valid", 32'(bus.txValid), 32'h1);
        end
        bus.txReady = 1'b1;
        tick(); chk("tx2 lo", 32'(bus.txByte), 32'hEF);
        tick(); chk("tx2 done", 32'(bus.transportBusy), 32'h0);

        // RX delivery latency
        rx_send(8'hA2); rx_send(8'h12); rx_send(8'h34);
        chk("rx1 early", 32'(bus.cmdOut), 32'h0);
        tick();
        chk("rx1 cmd", 32'(bus.cmdOut), 32'h2);
        chk("rx1 pkt", 32'(bus.packetOut), 32'h1234);
        tick();
        chk("rx1 cmd clr", 32'(bus.cmdOut), 32'h0);
        chk("rx1 pkt hold", 32'(bus.packetOut), 32'h1234);

        // Bad headers and timeout
        rx_send(8'h55); chk("rx bad hdr 55", 32'(bus.rxError), 32'h1);
        rx_send(8'hA0); chk("rx bad hdr A0", 32'(bus.rxError), 32'h1);
        tick(); chk("rx err clr", 32'(bus.rxError), 32'h0);
        rx_send(8'hA1); rx_send(8'h30);
        repeat (T - 1) tick();
        chk("rx pre-timeout", 32'(bus.rxError), 32'h0);
        tick(); chk("rx timeout", 32'(bus.rxError), 32'h1);
        tick(); chk("rx timeout no dlv", 32'(bus.packetOut), 32'h1234);

        // Overflow while session is busy
        bus.sessionBusy = 1'b1;
        rx_send(8'hA1); rx_send(8'h11); rx_send(8'h22);
        rx_send(8'hA2); rx_send(8'h33); rx_send(8'h44);
        chk("ovf pulse", 32'(bus.rxOverflow), 32'h1);
        bus.sessionBusy = 1'b0;
        tick();
        chk("ovf dlv cmd", 32'(bus.cmdOut), 32'h1);
        chk("ovf dlv pkt", 32'(bus.packetOut), 32'h1122);
        tick();
        chk("ovf single", 32'(bus.cmdOut), 32'h0);
        chk("ovf pkt kept", 32'(bus.packetOut), 32'h1122);

        // Reset in the middle of a TX frame
        bus.cmd = 2'b10; bus.dataIn = 16'h5678;
        tick(); chk("tx3 hdr", 32'(bus.txByte), 32'hA2);
        bus.cmd = 2'b00;
        tick(); chk("tx3 hi", 32'(bus.txByte), 32'h56);
        #2 reset = 1'b1;
        #1;
        chk("midrst txValid", 32'(bus.txValid), 32'h0);
        chk("midrst busy", 32'(bus.transportBusy), 32'h0);
        tick();
        #2 reset = 1'b0;
        bus.cmd = 2'b01; bus.dataIn = 16'h9ABC;
        tick(); chk("tx4 hdr", 32'(bus.txByte), 32'hA1);
        bus.cmd = 2'b00;
        tick(); chk("tx4 hi", 32'(bus.txByte), 32'h9A);
        tick(); chk("tx4 lo", 32'(bus.txByte), 32'hBC);
        tick(); chk("tx4 done", 32'(bus.transportBusy), 32'h0);

        // Randomized concurrent traffic
        for (int c = 0; c < 4000; c++) begin
            bus.cmd = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            bus.dataIn = 16'($urandom);
            bus.txReady = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 7) == 0)
                bus.sessionBusy = ($urandom_range(0, 2) == 0);
            if (gap > 0) begin
                bus.rxValid = 1'b0;
                gap--;
            end else if ($urandom_range(0, 149) == 0) begin
                bus.rxValid = 1'b0;
                gap = T + 2;
            end else if ($urandom_range(0, 2) == 0) begin
                bus.rxValid = 1'b1;
                if (rx_pos == 0)
                    bus.rxByte = ($urandom_range(0, 9) < 8) ? {SYNC, 2'b00, 2'($urandom_range(1, 3))}
                                                             : 8'($urandom);
                else
                    bus.rxByte = 8'($urandom);
                rx_pos = (rx_pos + 1) % 3;
            end else begin
                bus.rxValid = 1'b0;
            end
            if ($urandom_range(0, 999) == 0) begin
                #2 reset = 1'b1;
                #2 reset = 1'b0;
                rx_pos = 0;
            end
            tick();
        end

        checking = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
